// File: rtl/tcam_pkg.sv
// Shared TCAM constants and the per-bit ternary match rule used by the array
// and by verification models.
package tcam_pkg;

  localparam int unsigned TCAM_ADDR_W    = 2;
  localparam int unsigned TCAM_WORD_SIZE = 16;

  // A bit matches when either side marks it don't-care or the values agree.
  function automatic logic tcam_bit_match(input logic data_bit,
                                          input logic mask_bit,
                                          input logic key_bit,
                                          input logic key_mask_bit);
    return mask_bit | key_mask_bit | (data_bit == key_bit);
  endfunction

endpackage

// File: rtl/tcam_prio_enc.sv
// Match-vector encoder: any-hit flag, lowest set index, and more-than-one flag.
module tcam_prio_enc
  import tcam_pkg::*;
#(
  parameter int unsigned ADDR_W = TCAM_ADDR_W
) (
  input  logic [2**ADDR_W-1:0] match_vec,
  output logic                 hit,
  output logic [ADDR_W-1:0]    index,
  output logic                 multi
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0]  lowest;
  logic [ADDR_W-1:0] idx_acc [DEPTH+1];

  // Isolating the lowest set bit makes the index a plain OR of one-hot terms.
  assign lowest     = match_vec & (~match_vec + DEPTH'(1));
  assign idx_acc[0] = '0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_idx
    assign idx_acc[i+1] = idx_acc[i] | (lowest[i] ? ADDR_W'(i) : '0);
  end

  assign hit   = |match_vec;
  assign index = idx_acc[DEPTH];
  assign multi = |(match_vec & (match_vec - DEPTH'(1)));

endmodule

// File: rtl/tcam_seq.sv
// Pipelined ternary CAM: match vector in stage 1, priority result in stage 2.
// Optional TCAM_MATCH_COUNT_EN adds the res_count matching-entry popcount.
module tcam_seq
  import tcam_pkg::*;
#(
  parameter int unsigned ADDR_W    = TCAM_ADDR_W,
  parameter int unsigned WORD_SIZE = TCAM_WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic [WORD_SIZE-1:0] wr_mask,
  input  logic                 inv_en,
  input  logic                 clr_all,
  input  logic                 srch_en,
  input  logic [WORD_SIZE-1:0] srch_data,
  input  logic [WORD_SIZE-1:0] srch_mask,
  output logic                 res_valid,
  output logic                 res_hit,
  output logic [ADDR_W-1:0]    res_addr,
  output logic                 res_multi
`ifdef TCAM_MATCH_COUNT_EN
  , output logic [ADDR_W:0]    res_count
`endif
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  logic [WORD_SIZE-1:0] data_q [DEPTH];
  logic [WORD_SIZE-1:0] mask_q [DEPTH];
  logic [WORD_SIZE-1:0] bit_ok [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [DEPTH-1:0]     match_comb;
  logic [DEPTH-1:0]     match_q;
  logic                 s1_valid;
  logic                 enc_hit;
  logic                 enc_multi;
  logic [ADDR_W-1:0]    enc_addr;
  logic                 do_write;

  assign do_write = wr_en & ~inv_en & ~clr_all;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    for (genvar b = 0; b < WORD_SIZE; b++) begin : g_bit
      assign bit_ok[i][b] = tcam_bit_match(data_q[i][b], mask_q[i][b],
                                           srch_data[b], srch_mask[b]);
    end
    assign match_comb[i] = valid_q[i] & (&bit_ok[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
    end else if (inv_en) begin
      valid_q[wr_addr] <= 1'b0;
    end else if (wr_en) begin
      valid_q[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      data_q[wr_addr] <= wr_data;
      mask_q[wr_addr] <= wr_mask;
    end
  end

  // Stage 1 samples the pre-update contents, so same-cycle writes are not seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      match_q  <= '0;
    end else begin
      s1_valid <= srch_en;
      if (srch_en) match_q <= match_comb;
    end
  end

  tcam_prio_enc #(
    .ADDR_W(ADDR_W)
  ) u_prio_enc (
    .match_vec(match_q),
    .hit      (enc_hit),
    .index    (enc_addr),
    .multi    (enc_multi)
  );

`ifdef TCAM_MATCH_COUNT_EN
  logic [ADDR_W:0] cnt_acc [DEPTH+1];
  assign cnt_acc[0] = '0;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cnt
    assign cnt_acc[i+1] = cnt_acc[i] + (ADDR_W+1)'(match_q[i]);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_hit   <= 1'b0;
      res_addr  <= '0;
      res_multi <= 1'b0;
`ifdef TCAM_MATCH_COUNT_EN
      res_count <= '0;
`endif
    end else begin
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_hit   <= enc_hit;
        res_addr  <= enc_addr;
        res_multi <= enc_multi;
`ifdef TCAM_MATCH_COUNT_EN
        res_count <= cnt_acc[DEPTH];
`endif
      end
    end
  end

endmodule

// File: doc/tcam_seq.md
TCAM_SEQ -- requirements
Module: tcam_seq

Interface
REQ-001 Parameter ADDR_W, default 2: entry address width; DEPTH = 2**ADDR_W entries.
REQ-002 Parameter WORD_SIZE, default 16: key/entry width in bits.
REQ-003 Clocking SHALL be one clock, clk; reset rst SHALL be asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  async active-high reset.
REQ-006 wr_en  in  1  write entry at wr_addr, setting it valid.
REQ-007 wr_addr  in  ADDR_W  target entry for write/invalidate.
REQ-008 wr_data  in  WORD_SIZE  stored word.
REQ-009 wr_mask  in  WORD_SIZE  stored don't-care bits (1 = X).
REQ-010 inv_en  in  1  invalidate entry at wr_addr.
REQ-011 clr_all  in  1  invalidate all entries.
REQ-012 srch_en  in  1  issue search.
REQ-013 srch_data  in  WORD_SIZE  search key.
REQ-014 srch_mask  in  WORD_SIZE  key don't-care bits (1 = X).
REQ-015 res_valid  out  1  result strobe, one cycle per search.
REQ-016 res_hit  out  1  at least one entry matched.
REQ-017 res_addr  out  ADDR_W  lowest matching index; 0 when no hit.
REQ-018 res_multi  out  1  more than one entry matched.
REQ-019 res_count  out  ADDR_W+1  number of matching entries (macro only, see Configuration).

Function
REQ-020 Entry i SHALL match iff valid[i] and, for every bit b, wr_mask_i[b] | srch_mask[b] | (data_i[b] == srch_data[b]).
REQ-021 Pipeline: stage 1 registers DEPTH-bit match vector at edge of issue cycle T; stage 2 registers priority-encoded result; res_* valid in cycle T+2.
REQ-022 One search SHALL be accepted every cycle; no backpressure; back-to-back results in order.
REQ-023 res_valid SHALL be high exactly one cycle per accepted search; res_hit/res_addr/res_multi hold last values when res_valid is low.
REQ-024 Priority: lowest matching index wins.
REQ-025 Write/invalidate/clear take effect at the clock edge; a search issued in the same cycle SHALL see pre-update contents.
REQ-026 A write, invalidate or clr_all in cycle T+1 SHALL NOT alter the result of a search issued in cycle T.
REQ-027 Simultaneous control priority: clr_all > inv_en > wr_en; lower-priority op in that cycle is discarded.
REQ-028 Rewriting a valid entry SHALL overwrite data and mask; entry stays valid.
REQ-029 All-X key (srch_mask all ones) SHALL hit every valid entry; with all entries invalid, res_hit=0.

Reset
REQ-030 rst SHALL clear all valid bits, both pipeline stages, res_valid, res_hit, res_addr, res_multi, res_count to 0.
REQ-031 Searches in flight at reset SHALL be discarded; no res_valid until a new search.
REQ-032 Data/mask storage SHALL NOT require reset.

Configuration
REQ-033 Macro TCAM_MATCH_COUNT_EN defined: res_count present, registered in stage 2 with res_hit.
REQ-034 Macro undefined: res_count port and popcount logic absent; all other behaviour identical.

Structure
REQ-035 Shared package tcam_pkg SHALL hold default ADDR_W/WORD_SIZE constants and the match-function definition shared with the bench model.
REQ-036 Sub-module tcam_prio_enc (DEPTH-bit vector -> hit, index, multi) SHALL implement stage-2 encoding.

Verification (WORD_SIZE=16, ADDR_W=2)
REQ-037 Write 10,20,30,40 to entries 0..3, mask 0; search 30 -> T+2: res_hit=1, res_addr=2, res_multi=0; search 50 -> res_hit=0, res_addr=0.
REQ-038 Write entry 3 = 0x0008 mask 0x0020; search 40 -> res_addr=3; search 8 -> res_addr=3; search 6 -> res_hit=0.
REQ-039 Entries 1 and 3 both match key 0x0028 -> res_addr=1, res_multi=1, res_count=2 (macro on).
REQ-040 Search 30 in cycle T, inv_en entry 2 in cycle T -> result hits entry 2; repeat search in T+1 -> res_hit=0.
REQ-041 Searches on 4 consecutive cycles -> 4 consecutive res_valid pulses, results in issue order; clr_all in T+1 does not affect the T result.
REQ-042 Assert rst between issue and result -> no res_valid, all outputs 0, all entries invalid.
